// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the write-back stage: default data and
//               register-index widths, register count, the hard-wired zero
//               register index and the stage-register record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int BW       = 32;       // data word width
    localparam int RW       = 5;        // register index width
    localparam int NREG     = 2 ** RW;  // architectural register count
    localparam int ZERO_REG = 0;        // index that always reads zero

    // Stage-register record: a pending write waiting to commit.
    typedef struct packed {
        logic          v;     // pending write to a nonzero destination
        logic [RW-1:0] rd;    // destination index
        logic [BW-1:0] data;  // value to be written
    } wb_stage_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/write_back_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : NREG x BW register storage. One synchronous write port, two
//               combinational read ports. Index 0 is never written and always
//               reads zero.
// Ports       : clk                 - clock, rising edge
//               rst                 - synchronous active-low reset (clears all)
//               we, waddr, wdata    - write port
//               raddr1/2, rdata1/2  - combinational read ports
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import wb_pkg::*;
#(
    parameter int BW = wb_pkg::BW,
    parameter int RW = wb_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [RW-1:0] raddr1,
    input  logic [RW-1:0] raddr2,
    output logic [BW-1:0] rdata1,
    output logic [BW-1:0] rdata2
);

    localparam int          C_NREG = 2 ** RW;
    localparam logic [RW-1:0] C_ZERO = RW'(ZERO_REG);

    logic [BW-1:0] mem_q [C_NREG];
    logic [BW-1:0] mem_d [C_NREG];

    // Writes aimed at the zero register are dropped here as a second line of
    // defence; the stage never issues them in normal operation.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != C_ZERO)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < C_NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = (raddr1 == C_ZERO) ? '0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == C_ZERO) ? '0 : mem_q[raddr2];

endmodule : reg_file
`default_nettype wire

// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
// Module      : write_back
// Description : Write-back pipeline stage. Captures the memory-stage result in
//               a stage register, commits it to the register file one edge
//               later, bypasses the pending value to the decode read ports and
//               counts committed writes.
// Ports       : clk, rst                     - clock, sync active-low reset
//               valid_in, ReadData_in,
//               Origenal_in, MemtoReg,
//               RegWrite, rd_in              - memory-stage result
//               rs1_addr/rs2_addr            - decode read indices
//               rs1_data/rs2_data            - read data (bypassed)
//               fwd_valid/fwd_rd/fwd_data    - pending write, for forwarding
//               retire_cnt                   - committed-write counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module write_back
    import wb_pkg::*;
#(
    parameter int BW = wb_pkg::BW,
    parameter int RW = wb_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [BW-1:0] ReadData_in,
    input  logic [BW-1:0] Origenal_in,
    input  logic          MemtoReg,
    input  logic          RegWrite,
    input  logic [RW-1:0] rd_in,
    input  logic [RW-1:0] rs1_addr,
    input  logic [RW-1:0] rs2_addr,
    output logic [BW-1:0] rs1_data,
    output logic [BW-1:0] rs2_data,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [BW-1:0] fwd_data,
    output logic [31:0]   retire_cnt
);

    localparam logic [RW-1:0] C_ZERO = RW'(ZERO_REG);

    // Same layout as wb_pkg::wb_stage_t, sized from this instance's parameters.
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic [BW-1:0] data;
    } stage_t;

    stage_t        stage_d, stage_q;
    logic [31:0]   retire_cnt_d, retire_cnt_q;
    logic [BW-1:0] w_file_rs1, w_file_rs2;

    // ------------------------------------------------------------------------
    // Stage register. With valid_in low the index and data hold their last
    // value and only the valid bit drops. The load-data select is gated by
    // RegWrite so MemtoReg cannot influence a non-writing result.
    // ------------------------------------------------------------------------
    always_comb begin
        stage_d   = stage_q;
        stage_d.v = 1'b0;
        if (valid_in) begin
            stage_d.v    = RegWrite && (rd_in != C_ZERO);
            stage_d.rd   = rd_in;
            stage_d.data = (MemtoReg && RegWrite) ? ReadData_in : Origenal_in;
        end
    end

    // A valid stage entry commits on the next edge, so the count advances on
    // exactly those edges.
    always_comb begin
        retire_cnt_d = retire_cnt_q + {31'd0, stage_q.v};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    reg_file #(
        .BW (BW),
        .RW (RW)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (stage_q.v),
        .waddr  (stage_q.rd),
        .wdata  (stage_q.data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (w_file_rs1),
        .rdata2 (w_file_rs2)
    );

    // ------------------------------------------------------------------------
    // Read ports: the pending stage value is newer than anything in the file,
    // so it wins on an index match. The file itself already returns zero for
    // index 0, but the explicit test keeps x0 zero regardless of bypass state.
    // ------------------------------------------------------------------------
    always_comb begin
        rs1_data = w_file_rs1;
        rs2_data = w_file_rs2;
        if (rs1_addr == C_ZERO) begin
            rs1_data = '0;
        end else if (stage_q.v && (rs1_addr == stage_q.rd)) begin
            rs1_data = stage_q.data;
        end
        if (rs2_addr == C_ZERO) begin
            rs2_data = '0;
        end else if (stage_q.v && (rs2_addr == stage_q.rd)) begin
            rs2_data = stage_q.data;
        end
    end

    assign fwd_valid  = stage_q.v;
    assign fwd_rd     = stage_q.rd;
    assign fwd_data   = stage_q.data;
    assign retire_cnt = retire_cnt_q;

endmodule : write_back
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back
// Description : Self-checking bench for write_back: table of input vectors
//               with expected read/forward/counter values, a scoreboard queue
//               of pending writes checked against the forwarding outputs, and
//               hand-written sequences for reset, reset-abort and wrap cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back;
    import wb_pkg::*;

    typedef struct {
        logic        valid;
        logic        mtr;
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] orig;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_fv;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] ReadData_in;
    logic [31:0] Origenal_in;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  rd_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    wb_stage_t sb_q[$];
    vec_t      tbl[11];

    always #5 clk = ~clk;

    write_back #(.BW(32), .RW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ReadData_in (ReadData_in),
        .Origenal_in (Origenal_in),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .rd_in       (rd_in),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .retire_cnt  (retire_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        valid_in    = v.valid;
        MemtoReg    = v.mtr;
        RegWrite    = v.regw;
        rd_in       = v.rd;
        ReadData_in = v.rdata;
        Origenal_in = v.orig;
        rs1_addr    = v.rs1;
        rs2_addr    = v.rs2;
    endtask

    // Drive one vector, predict the stage capture into the scoreboard, and
    // after the edge compare the forwarding outputs against the oldest entry.
    task automatic apply(input vec_t v);
        wb_stage_t e;
        @(negedge clk);
        set_inputs(v);
        if (v.valid && v.regw && (v.rd != 5'd0)) begin
            e.v    = 1'b1;
            e.rd   = v.rd;
            e.data = v.mtr ? v.rdata : v.orig;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (fwd_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_fwd", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_fwd_rd", {27'd0, fwd_rd}, {27'd0, e.rd});
                check("sb_fwd_data", fwd_data, e.data);
            end
        end
    endtask

    function automatic vec_t idle(input logic [4:0] a1, input logic [4:0] a2);
        vec_t v;
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, a1, a2, 1'b0, 32'd0, 32'd0, 32'd0};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            valid mtr   regw  rd     rdata         orig          rs1    rs2    e_fv  e_rs1         e_rs2         e_cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'd27, 32'h88888888, 32'h12345678, 5'd27, 5'd0,  1'b1, 32'h88888888, 32'h00000000, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 5'd27, 5'd5,  1'b0, 32'h88888888, 32'h00000000, 32'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd21, 32'hDEADBEEF, 32'h77777777, 5'd27, 5'd21, 1'b1, 32'h88888888, 32'h77777777, 32'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 5'd21, 32'h00000000, 32'h66666666, 5'd21, 5'd21, 1'b1, 32'h66666666, 32'h66666666, 32'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 5'd21, 5'd27, 1'b0, 32'h66666666, 32'h88888888, 32'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'd0,  32'h00000000, 32'h55555555, 5'd0,  5'd0,  1'b0, 32'h00000000, 32'h00000000, 32'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h11111111, 32'h22222222, 5'd3,  5'd3,  1'b0, 32'h00000000, 32'h00000000, 32'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 5'd3,  5'd0,  1'b0, 32'h00000000, 32'h00000000, 32'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 5'd3,  32'hABCD0123, 32'h00000000, 5'd3,  5'd27, 1'b1, 32'hABCD0123, 32'h88888888, 32'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 5'd4,  32'h00000000, 32'hCAFEF00D, 5'd3,  5'd4,  1'b1, 32'hABCD0123, 32'hCAFEF00D, 32'd4};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd7,  32'h00000000, 32'h99999999, 5'd7,  5'd4,  1'b0, 32'h00000000, 32'hCAFEF00D, 32'd5};

        // Reset held for two edges, then released.
        rst = 1'b0;
        set_inputs(idle(5'd5, 5'd5));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_fwd_valid",  {31'd0, fwd_valid}, 32'd0);
        check("rst_fwd_rd",     {27'd0, fwd_rd},    32'd0);
        check("rst_fwd_data",   fwd_data,           32'd0);
        check("rst_retire_cnt", retire_cnt,         32'd0);
        check("rst_rs1_data",   rs1_data,           32'd0);
        check("rst_rs2_data",   rs2_data,           32'd0);

        // Table-driven main function.
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            check($sformatf("v%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, tbl[i].e_fv});
            check($sformatf("v%0d_rs1", i), rs1_data, tbl[i].e_rs1);
            check($sformatf("v%0d_rs2", i), rs2_data, tbl[i].e_rs2);
            check($sformatf("v%0d_cnt", i), retire_cnt, tbl[i].e_cnt);
        end

        // Reset aborts a pending write and dominates a simultaneous valid_in.
        @(negedge clk);
        set_inputs('{1'b1, 1'b1, 1'b1, 5'd9, 32'h44444444, 32'h0, 5'd9, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0});
        @(posedge clk);
        #1;
        check("abort_capture_fv", {31'd0, fwd_valid}, 32'd1);
        check("abort_capture_rs1", rs1_data, 32'h44444444);
        @(negedge clk);
        rst = 1'b0;
        set_inputs('{1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h33333333, 5'd9, 5'd4, 1'b0, 32'd0, 32'd0, 32'd0});
        @(posedge clk);
        #1;
        check("abort_fv", {31'd0, fwd_valid}, 32'd0);
        check("abort_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        set_inputs(idle(5'd9, 5'd4));
        @(posedge clk);
        #1;
        check("abort_rs1_entry9", rs1_data, 32'd0);
        check("abort_rs2_entry4", rs2_data, 32'd0);
        check("abort_cnt_after", retire_cnt, 32'd0);

        // Counter wrap: preload all-ones, then one commit.
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check("wrap_preload", retire_cnt, 32'hFFFFFFFF);
        apply('{1'b1, 1'b0, 1'b1, 5'd10, 32'h0, 32'h0BADF00D, 5'd10, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0});
        check("wrap_before_commit", retire_cnt, 32'hFFFFFFFF);
        apply(idle(5'd10, 5'd0));
        check("wrap_after_commit", retire_cnt, 32'd0);
        check("wrap_rs1_entry10", rs1_data, 32'h0BADF00D);

        check("sb_drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_write_back
`default_nettype wire
